// File: rtl/apu_sequencer_if.sv
// Register-write handshake between the host UART path, the sequencer and the
// registers block. The host side drives uart_*, the sequencer drives reg_*.
interface apu_sequencer_if;
  logic [3:0] uart_addr;
  logic [7:0] uart_data;
  logic       uart_ready;
  logic [3:0] reg_addr;
  logic [7:0] reg_data;
  logic       reg_ready;

  modport master (output uart_addr, output uart_data, output uart_ready,
                  input  reg_addr,  input  reg_data,  input  reg_ready);
  modport slave  (input  uart_addr, input  uart_data, input  uart_ready,
                  output reg_addr,  output reg_data,  output reg_ready);
endinterface

// File: rtl/apu_sequencer.sv
// Frame-tick driven note sequencer that shares the single register write port
// with host UART writes; host writes always win and are never dropped.
module apu_sequencer #(
  parameter int          STEPS    = 16,
  parameter int          TEMPO    = 8,
  parameter logic [7:0]  HI_BYTE  = 8'h08,
  parameter logic [7:0]  MUTE_VAL = 8'h30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_60hz,
  input  logic             play,
  input  logic             pat_we,
  input  logic [3:0]       pat_addr,
  input  logic [7:0]       pat_data,
  output logic [3:0]       step,
  output logic             busy,
  apu_sequencer_if.slave   bus
);

  localparam logic [3:0] STEP_LAST = 4'(STEPS - 1);
  localparam logic [7:0] FCNT_LAST = 8'(TEMPO - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_WR_LO, S_WR_HI, S_MUTE
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_mem [16];
  logic [3:0] r_step;
  logic [7:0] r_fcnt;
  logic [7:0] r_note;
  logic [3:0] r_reg_addr;
  logic [7:0] r_reg_data;
  logic       r_reg_ready;

  logic       w_req;
  logic       w_start;
  logic [3:0] w_req_addr;
  logic [7:0] w_req_data;
  logic [7:0] w_mem_rd;

  // Read happens before this edge's write lands, so a same-cycle write returns old data.
  assign w_mem_rd = r_mem[r_step];

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_start     = 1'b0;
    w_req_addr  = 4'h0;
    w_req_data  = 8'h00;
    case (r_state)
      S_IDLE: if (play) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (!play) begin
          w_state_nxt = S_MUTE;
        end else if (enable_60hz && (r_fcnt == 8'd0)) begin
          w_start = 1'b1;
          if (w_mem_rd != 8'h00) w_state_nxt = S_WR_LO;
        end
      end
      S_WR_LO: begin
        w_req      = 1'b1;
        w_req_addr = 4'h2;
        w_req_data = r_note;
        if (!bus.uart_ready) w_state_nxt = S_WR_HI;
      end
      S_WR_HI: begin
        w_req      = 1'b1;
        w_req_addr = 4'h3;
        w_req_data = HI_BYTE;
        if (!bus.uart_ready) w_state_nxt = S_WAIT;
      end
      S_MUTE: begin
        w_req      = 1'b1;
        w_req_addr = 4'h0;
        w_req_data = MUTE_VAL;
        if (!bus.uart_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= 8'h00;
    end else if (pat_we) begin
      r_mem[pat_addr] <= pat_data;
    end
  end

  // Step and frame counter are zeroed on the way into IDLE so step reads 0 there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step <= 4'd0;
      r_fcnt <= 8'd0;
      r_note <= 8'h00;
    end else begin
      if (w_state_nxt == S_IDLE) r_step <= 4'd0;
      else if (w_start)          r_step <= (r_step == STEP_LAST) ? 4'd0 : r_step + 4'd1;

      if ((r_state == S_IDLE) || (w_state_nxt == S_IDLE)) r_fcnt <= 8'd0;
      else if (enable_60hz) r_fcnt <= (r_fcnt == FCNT_LAST) ? 8'd0 : r_fcnt + 8'd1;

      if (w_start) r_note <= w_mem_rd;
    end
  end

  // Host request pre-empts the sequencer; the held request retries next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg_addr  <= 4'h0;
      r_reg_data  <= 8'h00;
      r_reg_ready <= 1'b0;
    end else if (bus.uart_ready) begin
      r_reg_addr  <= bus.uart_addr;
      r_reg_data  <= bus.uart_data;
      r_reg_ready <= 1'b1;
    end else if (w_req) begin
      r_reg_addr  <= w_req_addr;
      r_reg_data  <= w_req_data;
      r_reg_ready <= 1'b1;
    end else begin
      r_reg_ready <= 1'b0;
    end
  end

  assign bus.reg_addr  = r_reg_addr;
  assign bus.reg_data  = r_reg_data;
  assign bus.reg_ready = r_reg_ready;
  assign step          = r_step;
  assign busy          = (r_state == S_WR_LO) || (r_state == S_WR_HI) || (r_state == S_MUTE);

endmodule

// File: doc/apu_sequencer.md
# apu_sequencer

Autonomous note sequencer and register-write arbiter for the APU. It sits between the UART command path and the `registers` block and owns the single register write port. On frame ticks it steps through a 16-entry pattern memory and issues square1 period writes (0x2, then 0x3). Host UART writes always take priority and are never dropped.

## Interface
- `STEPS`, 16: pattern length, 1..16; step index wraps from STEPS-1 to 0.
- `TEMPO`, 8: frames per step, 1..255.
- `HI_BYTE`, 8'h08: data written to reg 0x3 after each note; the 0x3 write triggers the note event.
- `MUTE_VAL`, 8'h30: data written to reg 0x0 on stop (constant volume 0).

- `clk` in 1: APU clock.
- `reset` in 1: asynchronous reset, active-high.
- `enable_60hz` in 1: one-cycle frame tick from `frame`.
- `play` in 1: level; 1 = run pattern, 0 = stop.
- `uart_addr` in 4, `uart_data` in 8, `uart_ready` in 1: host write request; `uart_ready` is a one-cycle pulse.
- `pat_we` in 1, `pat_addr` in 4, `pat_data` in 8: pattern memory write port.
- `reg_addr` out 4, `reg_data` out 8, `reg_ready` out 1: registered write to `registers`; `reg_ready` is a one-cycle pulse.
- `step` out 4: index of the next step to play.
- `busy` out 1: 1 while in WR_LO, WR_HI or MUTE.

## Operation
- Pattern memory: 16x8 flops, cleared to 0 by reset. A write occurs at the clock edge when `pat_we`=1. A same-cycle read of the same address returns the old data. Entry 0 = rest (no writes). Nonzero = note (period low byte).
- Frame counter `fcnt` (8 bit, not a port):
  - Advances on every `enable_60hz` while not IDLE: `fcnt` = (`fcnt`==TEMPO-1) ? 0 : `fcnt`+1.
  - Cleared in IDLE.
- States:
  - IDLE: `step`=0, `fcnt`=0. If `play`=1, go to WAIT.
  - WAIT:
    - If `play`=0, go to MUTE. This check has priority over the tick.
    - Else, on `enable_60hz` with `fcnt`==0: latch `note`=mem[`step`] and set `step`=(`step`==STEPS-1)?0:`step`+1. If `note`!=0 go to WR_LO, else stay in WAIT.
  - WR_LO: request write {0x2, `note`}. When granted, go to WR_HI.
  - WR_HI: request write {0x3, HI_BYTE}. When granted, go to WAIT.
  - MUTE: request write {0x0, MUTE_VAL}. When granted, go to IDLE.
- A `play` drop during WR_LO/WR_HI finishes the burst first. MUTE then follows from WAIT.
- A tick arriving in WR_LO/WR_HI/MUTE still advances `fcnt`, but it does not start a step.
- Arbitration, per cycle:
  - If `uart_ready`=1, the output register loads {`uart_addr`, `uart_data`} and any sequencer request is held (not granted).
  - Else, if the state requests a write, the output register loads the request and the request is granted.
  - Otherwise `reg_ready`=0, and `reg_addr`/`reg_data` hold their last values.
- Host writes are forwarded in all states, including IDLE.

## Timing
- Reset values: `reg_addr`=0, `reg_data`=0, `reg_ready`=0, `step`=0, `busy`=0, state IDLE, `fcnt`=0, `note`=0.
- Reset mid-burst: all state clears immediately; the pending write is discarded.
- Host latency: `uart_ready` at cycle N gives `reg_ready`=1 at N+1 with the captured address and data.
- Note burst, uncontended: tick at N → WR_LO during N+1 → `reg_ready` (addr 0x2) at N+2 → WR_HI during N+2 → `reg_ready` (addr 0x3) at N+3 → WAIT at N+3. `busy`=1 at N+1..N+2.
- Collision: each `uart_ready` pulse in WR_LO/WR_HI/MUTE delays that sequencer write by exactly one cycle.
- Steps start every TEMPO ticks. The first step starts on the first tick after entering WAIT.
- `play` rise at N: WAIT at N+1.
- `play`=0 seen in WAIT at N: MUTE at N+1, `reg_ready` (0x0) at N+2, IDLE at N+2 with `step`=0.

## Test plan
- Reset: assert `reset` mid-burst → all outputs 0 asynchronously; no further `reg_ready`.
- Host passthrough: in IDLE, pulse `uart_ready` with addr 0x5, data 0xA7 → one cycle later `reg_ready`=1, 0x5/0xA7.
- Pattern: mem[0]=0x40, mem[1]=0, mem[2]=0x55, STEPS=3, TEMPO=2, `play`=1, ticks at T0..T5:
  - T0: writes (0x2,0x40) then (0x3,0x08).
  - T2: no writes.
  - T4: writes (0x2,0x55) then (0x3,0x08).
  - `step` wraps 2→0.
- Collision: `uart_ready` (0xB, 0x11) in the same cycle as the WR_LO request → host write at N+1, (0x2,note) at N+2, (0x3,0x08) at N+3; nothing lost.
- Stop: drop `play` during WR_LO → burst completes, then (0x0,0x30) is written, IDLE is reached, and `step`=0.
- Pattern memory: a `pat_we` write to the address read by the same tick → old entry is played; the new entry is played on the next wrap.
